// File: rtl/register_bank_mp.sv
// Multi-word register bank: one byte-masked write port, two tri-state read
// ports, async reset/preset, optional zero register and write-to-read bypass.
module register_bank_mp #(
   parameter int NrOfBits    = 32,
   parameter int NrOfRegs    = 32,
   parameter int AddrBits    = 5,
   parameter int ActiveLevel = 1,
   parameter int ZeroReg     = 1,
   parameter int Bypass      = 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  ClockEnable,
   input  logic                  Tick,
   input  logic                  pre,
   input  logic                  WrEn,
   input  logic [AddrBits-1:0]   WrAddr,
   input  logic [NrOfBits-1:0]   WrData,
   input  logic [NrOfBits/8-1:0] ByteEn,
   input  logic [AddrBits-1:0]   RdAddrA,
   input  logic [AddrBits-1:0]   RdAddrB,
   input  logic                  csA,
   input  logic                  csB,
   output logic [NrOfBits-1:0]   QA,
   output logic [NrOfBits-1:0]   QB
);

   localparam int NrOfLanes = NrOfBits / 8;

   logic                w_commit;
   logic                w_wr_ok;
   logic                w_set;
   logic                w_byp;
   logic [NrOfBits-1:0] w_mask;
   logic [NrOfBits-1:0] w_rd_a;
   logic [NrOfBits-1:0] w_rd_b;
   logic [NrOfBits-1:0] w_mem [NrOfRegs];

   assign w_commit = WrEn & ClockEnable & Tick;
   assign w_wr_ok  = (int'(WrAddr) < NrOfRegs) &&
                     !((ZeroReg != 0) && (WrAddr == '0));
   // Preset only takes effect once Reset is released, so a preset held
   // across the release of Reset still loads all-ones.
   assign w_set    = pre & ~Reset;
   assign w_byp    = (Bypass != 0) && w_commit && !Reset && !pre && w_wr_ok;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NrOfLanes; i++) begin
         w_mask[8*i +: 8] = {8{ByteEn[i]}};
      end
   end

   for (genvar g = 0; g < NrOfRegs; g++) begin : g_word
      if ((ZeroReg != 0) && (g == 0)) begin : g_zero
         assign w_mem[g] = '0;
      end else begin : g_reg
         logic [NrOfBits-1:0] r_word;
         logic [NrOfBits-1:0] w_next;
         logic                w_hit;

         assign w_hit  = w_commit && (WrAddr == AddrBits'(g));
         assign w_next = w_hit ? ((r_word & ~w_mask) | (WrData & w_mask))
                               : r_word;

         if (ActiveLevel != 0) begin : g_pos
            always_ff @(posedge Clock or posedge Reset or posedge w_set) begin
               if (Reset)      r_word <= '0;
               else if (w_set) r_word <= '1;
               else            r_word <= w_next;
            end
         end else begin : g_neg
            always_ff @(negedge Clock or posedge Reset or posedge w_set) begin
               if (Reset)      r_word <= '0;
               else if (w_set) r_word <= '1;
               else            r_word <= w_next;
            end
         end

         assign w_mem[g] = r_word;
      end
   end

   always_comb begin
      w_rd_a = '0;
      if (int'(RdAddrA) < NrOfRegs) w_rd_a = w_mem[RdAddrA];
      if (w_byp && (RdAddrA == WrAddr))
         w_rd_a = (w_rd_a & ~w_mask) | (WrData & w_mask);
   end

   always_comb begin
      w_rd_b = '0;
      if (int'(RdAddrB) < NrOfRegs) w_rd_b = w_mem[RdAddrB];
      if (w_byp && (RdAddrB == WrAddr))
         w_rd_b = (w_rd_b & ~w_mask) | (WrData & w_mask);
   end

   assign QA = csA ? {NrOfBits{1'bz}} : w_rd_a;
   assign QB = csB ? {NrOfBits{1'bz}} : w_rd_b;

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: rising-edge/bypass and falling-edge/no-bypass
// instances on shared stimulus, checked against an array model each half cycle.
module tb_register_bank_mp;

   localparam int W = 32;
   localparam int N = 32;
   localparam int A = 6;

   logic         Clock = 0;
   logic         Reset = 0;
   logic         ClockEnable = 0;
   logic         Tick = 0;
   logic         pre = 0;
   logic         WrEn = 0;
   logic [A-1:0] WrAddr = '0;
   logic [W-1:0] WrData = '0;
   logic [3:0]   ByteEn = '0;
   logic [A-1:0] RdAddrA = '0;
   logic [A-1:0] RdAddrB = '0;
   logic         csA = 0;
   logic         csB = 0;
   wire  [W-1:0] QA0, QB0, QA1, QB1;

   register_bank_mp #(
      .NrOfBits(W), .NrOfRegs(N), .AddrBits(A),
      .ActiveLevel(1), .ZeroReg(1), .Bypass(1)
   ) u_dut0 (
      .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable),
      .Tick(Tick), .pre(pre), .WrEn(WrEn), .WrAddr(WrAddr),
      .WrData(WrData), .ByteEn(ByteEn), .RdAddrA(RdAddrA),
      .RdAddrB(RdAddrB), .csA(csA), .csB(csB), .QA(QA0), .QB(QB0)
   );

   register_bank_mp #(
      .NrOfBits(W), .NrOfRegs(N), .AddrBits(A),
      .ActiveLevel(0), .ZeroReg(1), .Bypass(0)
   ) u_dut1 (
      .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable),
      .Tick(Tick), .pre(pre), .WrEn(WrEn), .WrAddr(WrAddr),
      .WrData(WrData), .ByteEn(ByteEn), .RdAddrA(RdAddrA),
      .RdAddrB(RdAddrB), .csA(csA), .csB(csB), .QA(QA1), .QB(QB1)
   );

   always #5 Clock = ~Clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;
   bit prev_clk = 0;
   logic [W-1:0] m0 [N];
   logic [W-1:0] m1 [N];

   function automatic logic [W-1:0] lanes(input logic [W-1:0] old,
                                          input logic [W-1:0] data,
                                          input logic [3:0] be);
      logic [W-1:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
      return r;
   endfunction

   function automatic bit writable(input logic [A-1:0] a);
      return (a != '0) && (int'(a) < N);
   endfunction

   function automatic bit commit();
      return WrEn && ClockEnable && Tick && !Reset && !pre;
   endfunction

   // Model: dut0 stores on rising edges, dut1 on falling edges.
   always @(Clock or Reset or pre) begin
      if (Reset) begin
         for (int i = 0; i < N; i++) begin m0[i] = '0; m1[i] = '0; end
      end else if (pre) begin
         for (int i = 1; i < N; i++) begin m0[i] = '1; m1[i] = '1; end
      end else if ((Clock != prev_clk) && commit() && writable(WrAddr)) begin
         if (Clock) m0[WrAddr] = lanes(m0[WrAddr], WrData, ByteEn);
         else       m1[WrAddr] = lanes(m1[WrAddr], WrData, ByteEn);
      end
      prev_clk = Clock;
   end

   function automatic logic [W-1:0] exp_rd(input bit neg, input logic [A-1:0] a);
      logic [W-1:0] v;
      v = '0;
      if (writable(a)) v = neg ? m1[a] : m0[a];
      if (!neg && commit() && writable(WrAddr) && (a == WrAddr))
         v = lanes(v, WrData, ByteEn);
      return v;
   endfunction

   task automatic check(input string nm, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // A 2-state simulator reads an undriven port as zero.
   task automatic check_z(input string nm, input logic [W-1:0] act);
      n_cmp++;
      if (!(act === {W{1'bz}} || act === '0)) begin
         n_bad++;
         $display("FAIL %s: got %h, expected high-Z at %0t", nm, act, $time);
      end
   endtask

   always @(Clock) begin
      #3;
      if (chk_en) begin
         if (csA) begin
            check_z("QA0 hiz", QA0);
            check_z("QA1 hiz", QA1);
         end else begin
            check("QA0", QA0, exp_rd(0, RdAddrA));
            check("QA1", QA1, exp_rd(1, RdAddrA));
         end
         if (csB) begin
            check_z("QB0 hiz", QB0);
            check_z("QB1 hiz", QB1);
         end else begin
            check("QB0", QB0, exp_rd(0, RdAddrB));
            check("QB1", QB1, exp_rd(1, RdAddrB));
         end
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d,
                     input logic [3:0] be, input logic tk);
      WrEn = 1; ClockEnable = 1; Tick = tk;
      WrAddr = a; WrData = d; ByteEn = be;
   endtask

   task automatic idle();
      WrEn = 0; Tick = 0; ClockEnable = 0;
   endtask

   logic [A-1:0] ta [5] = '{6'd1, 6'd2, 6'd9, 6'd31, 6'd16};
   logic [W-1:0] td [5] = '{32'h0102_0304, 32'hCAFE_F00D, 32'h8765_4321,
                            32'hFFFF_0000, 32'h5A5A_A5A5};
   logic [3:0]   tb_be [5] = '{4'b1111, 4'b1010, 4'b1111, 4'b0110, 4'b1001};

   initial begin
      #1 Reset = 1;
      step(); step();
      Reset = 0; chk_en = 1;
      RdAddrA = 6'd3; RdAddrB = 6'd0;
      #2 check("reset QA0", QA0, 32'h0);
      check("reset QB1", QB1, 32'h0);

      step(); wr(6'd3, 32'hA5A5_1234, 4'b1111, 1);
      step(); idle();
      #2 check("full wr QA0", QA0, 32'hA5A5_1234);
      check("full wr QA1", QA1, 32'hA5A5_1234);

      step(); wr(6'd3, 32'h0, 4'b1111, 0);
      step(); wr(6'd3, 32'h0, 4'b1111, 1); ClockEnable = 0;
      step(); idle();
      #2 check("tick0/ce0 QA0", QA0, 32'hA5A5_1234);

      step(); wr(6'd3, 32'hDEAD_BEEF, 4'b0101, 1);
      step(); wr(6'd3, 32'h0, 4'b0000, 1);
      step(); idle();
      #2 check("lanes QA0", QA0, 32'hA5AD_12EF);
      check("lanes QA1", QA1, 32'hA5AD_12EF);

      step(); wr(6'd7, 32'h1111_1111, 4'b1111, 1);
      step(); wr(6'd7, 32'h0000_00FF, 4'b0001, 1); RdAddrA = 6'd7;
      #2 check("bypass QA0", QA0, 32'h1111_11FF);
      check("no bypass QA1", QA1, 32'h1111_1111);
      #5 check("negedge QA1", QA1, 32'h1111_11FF);
      step(); idle();
      #2 check("after edge QA0", QA0, 32'h1111_11FF);

      step(); wr(6'd0, 32'hFFFF_FFFF, 4'b1111, 1); RdAddrA = 6'd0;
      #2 check("zreg byp QA0", QA0, 32'h0);
      step(); idle();
      #2 check("zreg QA0", QA0, 32'h0);
      check("zreg QA1", QA1, 32'h0);

      step(); wr(6'd40, 32'h1234_5678, 4'b1111, 1);
      RdAddrA = 6'd8; RdAddrB = 6'd40;
      #2 check("oob rd QB0", QB0, 32'h0);
      step(); idle();
      #2 check("oob alias QA0", QA0, 32'h0);
      check("oob alias QA1", QA1, 32'h0);

      for (int i = 0; i < 5; i++) begin
         step(); wr(ta[i], td[i], tb_be[i], 1);
         RdAddrA = ta[i]; RdAddrB = 6'd3;
      end
      step(); idle();
      for (int a = 0; a < N + 2; a++) begin
         step();
         RdAddrA = A'(a);
         RdAddrB = A'(N + 1 - a);
      end

      step(); csA = 1; csB = 0; RdAddrA = 6'd3; RdAddrB = 6'd3;
      #2 check_z("csA QA0", QA0);
      check("csB QB0", QB0, 32'hA5AD_12EF);
      check("csB QB1", QB1, 32'hA5AD_12EF);
      step(); csA = 0; csB = 1;
      #2 check_z("csB QB0", QB0);
      check("csA QA0", QA0, 32'hA5AD_12EF);
      step(); csB = 0;

      step(); RdAddrA = 6'd3; RdAddrB = 6'd5; Reset = 1;
      #2 check("async rst QA0", QA0, 32'h0);
      check("async rst QA1", QA1, 32'h0);
      step(); pre = 1;
      #2 check("pre in rst QB0", QB0, 32'h0);
      step(); Reset = 0; RdAddrA = 6'd0;
      wr(6'd5, 32'h0, 4'b1111, 1);
      #2 check("pre QB0", QB0, 32'hFFFF_FFFF);
      check("pre QB1", QB1, 32'hFFFF_FFFF);
      check("pre zreg QA0", QA0, 32'h0);
      step(); step(); idle(); pre = 0;
      #2 check("pre hold QB0", QB0, 32'hFFFF_FFFF);
      check("pre hold QB1", QB1, 32'hFFFF_FFFF);
      step(); step();
      chk_en = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
- Parametrised multi-register storage block for the single-cycle RISC-V datapath.
- Generalises the single tick-gated, presettable, tri-state register to a bank of NrOfRegs words.
- Provides one byte-lane-masked write port and two independent tri-state read ports.
- Adds an optional hardwired-zero register 0, optional write-to-read bypass, and selectable active clock edge.

Parameters:
- NrOfBits, 32, word width; must be a multiple of 8.
- NrOfRegs, 32, number of words; 2..2^AddrBits.
- AddrBits, 5, address width of all address ports.
- ActiveLevel, 1, 1 = state updates on rising Clock edge; 0 = on falling edge.
- ZeroReg, 1, 1 = word 0 always reads 0 and ignores writes/preset.
- Bypass, 1, 1 = read of the word being written this cycle returns the post-write value combinationally.

Ports:
- Clock  in  1  bank clock.
- Reset  in  1  asynchronous, active-high; clears all words.
- ClockEnable  in  1  global write qualifier.
- Tick  in  1  clock-gating tick; a write requires ClockEnable&Tick.
- pre  in  1  asynchronous, active-high preset; all words forced to all-ones.
- WrEn  in  1  write request.
- WrAddr  in  AddrBits  write word address.
- WrData  in  NrOfBits  write data.
- ByteEn  in  NrOfBits/8  per-lane write enable; bit i covers WrData[8i+7:8i].
- RdAddrA  in  AddrBits  read port A address.
- RdAddrB  in  AddrBits  read port B address.
- csA  in  1  1 = QA high-Z.
- csB  in  1  1 = QB high-Z.
- QA  out  NrOfBits  read port A data.
- QB  out  NrOfBits  read port B data.

Behaviour:
Reset and preset
- Reset is asynchronous: every word goes to 0 immediately.
- pre is asynchronous: every word goes to all-ones immediately, except word 0 when ZeroReg=1.
- Reset has priority over pre; pre has priority over any write.
- While Reset or pre is held, writes have no effect.
- After Reset, QA/QB read 0 unless the corresponding cs is high.

Write
- Write commit = WrEn & ClockEnable & Tick, sampled at the active edge selected by ActiveLevel.
- A committed write updates only the lanes whose ByteEn bit is 1; other lanes hold their value.
- ByteEn = 0 makes the write a no-op.
- Ignored writes: WrAddr >= NrOfRegs, and WrAddr = 0 when ZeroReg=1.
- One word is written per edge; write latency is one active edge.

Read (combinational, zero latency)
- QX = high-Z on all bits when csX = 1, independent of address and state.
- Otherwise QX = stored word at RdAddrX.
- RdAddrX >= NrOfRegs reads 0.
- RdAddrX = 0 reads 0 when ZeroReg=1.

Bypass (Bypass=1)
- Applies when a commit is pending (WrEn&ClockEnable&Tick), Reset and pre are low, and RdAddrX == WrAddr is a writable address.
- In that case QX = WrData on enabled lanes and the stored word on the other lanes.
- With Bypass=0, QX shows the old value until after the edge.

Other rules
- Ports A and B are fully independent and may read the same address.
- Simultaneous read and write of word 0 with ZeroReg=1: the read returns 0, with no bypass.
- Tick low at the edge: no update regardless of WrEn.

Test Plan:
- Reset pulse mid-cycle, with no clock edge, after words hold values -> all reads 0 immediately. Assert pre with Reset high -> reads stay 0. Drop Reset with pre high -> word 5 reads FFFFFFFF, word 0 reads 0.
- ActiveLevel=1: WrEn=1, Tick=1, CE=1, WrAddr=3, WrData=A5A5_1234, ByteEn=1111 -> after rising edge QA(3)=A5A51234. Repeat with Tick=0 -> word unchanged.
- Word 3 = A5A51234; write DEADBEEF with ByteEn=0101 -> word 3 = A5AD12EF.
- Bypass=1: WrAddr=RdAddrA=7, WrData=0000_00FF, ByteEn=0001, stored 1111_1111 -> QA=111111FF before the edge. Bypass=0 -> QA=11111111 before the edge and 111111FF after.
- ZeroReg=1: write FFFFFFFF to word 0 -> QA(0)=0. WrAddr=40 with NrOfRegs=32 -> no word changes. RdAddrB=40 -> QB=0.
- csA=1, csB=0, same address -> QA all Z, QB valid. ActiveLevel=0 -> write appears only after the falling edge.
